rsalign_seq: RTL
================

RSALIGN_SEQ -- requirements
Module: rsalign_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_l  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port fpuhold  input  1  stall; when 1, all internal state and registered outputs hold.
REQ-004 SHALL have port start  input  1  begin alignment; sampled only in IDLE.
REQ-005 SHALL have port ediff  input  12  unsigned exponent difference (right-shift distance); sampled with start.
REQ-006 SHALL have port dprec  input  1  1 = double precision, 0 = single; sampled with start.
REQ-007 SHALL have port a0zero  input  1  from datapath: word discarded by the current 32-bit shift is all zero.
REQ-008 SHALL have port shout_zero  input  1  from datapath: bits discarded by the current fractional shift are all zero.
REQ-009 SHALL have port rsfunc  output  3  shift function code to downstream rsadd control.
REQ-010 SHALL have port rs32  output  1  current cycle is a 32-bit word shift.
REQ-011 SHALL have port shamt  output  5  fractional shift amount, 0..31.
REQ-012 SHALL have port sticky  output  1  accumulated sticky of all discarded bits.
REQ-013 SHALL have ports busy and done  output  1 each  sequence active / one-cycle completion pulse.

Function
REQ-014 SHALL implement a 4-state FSM: IDLE, SH32, SHFRAC, DONE.
REQ-015 SHALL, in IDLE with start=1 and fpuhold=0, load rem = min(ediff, 64) if dprec=1, else min(ediff, 32), and clear sticky.
REQ-016 SHALL transition from IDLE on start: to SH32 if rem>=32, else to SHFRAC if rem!=0, else to DONE.
REQ-017 SHALL, in SH32, drive rsfunc=3'h6, rs32=1, shamt=0, subtract 32 from rem, and set sticky |= ~a0zero.
REQ-018 SHALL leave SH32 as follows: stay if the updated rem>=32, else go to SHFRAC if rem!=0, else go to DONE.
REQ-019 SHALL, in SHFRAC, drive rsfunc=3'h5, rs32=0, shamt=rem[4:0], set sticky |= ~shout_zero, clear rem, and go to DONE.
REQ-020 SHALL, in DONE, drive rsfunc=3'h3 and done=1 for exactly one unstalled cycle, then go to IDLE.
REQ-021 SHALL, in IDLE, drive rsfunc=3'h0, rs32=0, shamt=0, done=0, and hold sticky at its last value.
REQ-022 SHALL drive busy=1 in SH32, SHFRAC and DONE, and busy=0 in IDLE.
REQ-023 SHALL decode outputs from registered state only (Moore); a0zero and shout_zero affect only the next-state sticky value.
REQ-024 SHALL give a latency from the start cycle to done of floor(c/32) + (c%32!=0) + 1 cycles, where c is the clamped rem.
REQ-025 SHALL ignore start while busy=1, and SHALL ignore start in IDLE while fpuhold=1.
REQ-026 SHALL, while fpuhold=1, freeze state, rem, sticky and all outputs, including a pending done; done reasserts only after the hold is released.
REQ-027 SHALL hold rem at 7 bits internally, so ediff values greater than 64 never wrap or produce an extra shift cycle.

Reset
REQ-028 SHALL, on reset_l=0 at any time including mid-sequence, force IDLE, rem=0, sticky=0, rsfunc=0, rs32=0, shamt=0, busy=0 and done=0 asynchronously.
REQ-029 SHALL leave IDLE on the first rising clk edge after reset_l deasserts only if start=1.

Verification
REQ-030 SHALL cover: ediff=0, dprec=1, start -> next cycle DONE with done=1, rsfunc=3, sticky=0; following cycle IDLE with busy=0.
REQ-031 SHALL cover: ediff=40, dprec=1, a0zero=1, shout_zero=0 -> SH32 (rsfunc=6, rs32=1), then SHFRAC (rsfunc=5, shamt=8), then DONE with sticky=1.
REQ-032 SHALL cover: ediff=200, dprec=0, a0zero=0 -> exactly one SH32 cycle, then DONE with sticky=1 and no SHFRAC cycle.
REQ-033 SHALL cover: ediff=64, dprec=1, fpuhold=1 for 3 cycles during the first SH32 -> outputs frozen, then a second SH32, then DONE; total 6 cycles.
REQ-034 SHALL cover: reset_l pulsed low during SHFRAC -> outputs 0 immediately, no done pulse, and a subsequent ediff=5 start completes normally.
REQ-035 SHALL cover: start held high through a whole ediff=33 sequence -> only one sequence runs, then a new sequence starts from the IDLE cycle that follows DONE.

Source files
------------

// File: rtl/rsalign_seq.sv
// rtl/rsalign_seq.sv - right-shift alignment sequencer for the FPU adder
// Breaks an exponent-difference shift into 32-bit word shifts plus one fractional shift.
module rsalign_seq (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        fpuhold,
  input  logic        start,
  input  logic [11:0] ediff,
  input  logic        dprec,
  input  logic        a0zero,
  input  logic        shout_zero,
  output logic [2:0]  rsfunc,
  output logic        rs32,
  output logic [4:0]  shamt,
  output logic        sticky,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SH32   = 2'd1,
    S_SHFRAC = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [6:0] r_rem;
  logic [6:0] w_rem_next;
  logic [6:0] w_rem_clamp;
  logic [6:0] w_rem_sub;
  logic       r_sticky;
  logic       w_sticky_next;

  // Clamp to the mantissa width: anything past it is shifted out entirely.
  always_comb begin
    w_rem_clamp = ediff[6:0];
    if (dprec) begin
      if (ediff >= 12'd64) w_rem_clamp = 7'd64;
    end else begin
      if (ediff >= 12'd32) w_rem_clamp = 7'd32;
    end
  end

  assign w_rem_sub = r_rem - 7'd32;

  always_comb begin
    w_state_next  = r_state;
    w_rem_next    = r_rem;
    w_sticky_next = r_sticky;
    if (!fpuhold) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_rem_next    = w_rem_clamp;
            w_sticky_next = 1'b0;
            if (w_rem_clamp >= 7'd32)      w_state_next = S_SH32;
            else if (w_rem_clamp != 7'd0)  w_state_next = S_SHFRAC;
            else                           w_state_next = S_DONE;
          end
        end
        S_SH32: begin
          w_rem_next    = w_rem_sub;
          w_sticky_next = r_sticky | ~a0zero;
          if (w_rem_sub >= 7'd32)      w_state_next = S_SH32;
          else if (w_rem_sub != 7'd0)  w_state_next = S_SHFRAC;
          else                         w_state_next = S_DONE;
        end
        S_SHFRAC: begin
          w_rem_next    = 7'd0;
          w_sticky_next = r_sticky | ~shout_zero;
          w_state_next  = S_DONE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= S_IDLE;
      r_rem    <= 7'd0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rem    <= w_rem_next;
      r_sticky <= w_sticky_next;
    end
  end

  // Outputs depend only on registered state so datapath zero flags never loop back combinationally.
  always_comb begin
    rsfunc = 3'h0;
    rs32   = 1'b0;
    shamt  = 5'd0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_SH32: begin
        rsfunc = 3'h6;
        rs32   = 1'b1;
        busy   = 1'b1;
      end
      S_SHFRAC: begin
        rsfunc = 3'h5;
        shamt  = r_rem[4:0];
        busy   = 1'b1;
      end
      S_DONE: begin
        rsfunc = 3'h3;
        busy   = 1'b1;
        done   = 1'b1;
      end
      default: begin
        rsfunc = 3'h0;
      end
    endcase
  end

  assign sticky = r_sticky;

endmodule
